// File: rtl/tone_mixer_if.sv
// Tone mixer control/audio bundle: per-channel note, volume, gate and
// routing in; stereo samples and envelope-activity flags out.
interface tone_mixer_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 22,
    parameter int VOL_W = 4
);
    logic [NCH*DIV_W-1:0] note_div;
    logic [NCH*VOL_W-1:0] volume;
    logic [NCH-1:0]       gate;
    logic [2*NCH-1:0]     route;
    logic [15:0]          audio_left;
    logic [15:0]          audio_right;
    logic [NCH-1:0]       active;

    modport master (
        output note_div, volume, gate, route,
        input  audio_left, audio_right, active
    );

    modport slave (
        input  note_div, volume, gate, route,
        output audio_left, audio_right, active
    );
endinterface

// File: rtl/tone_mixer.sv
// Multi-channel square-wave tone mixer with linear envelopes and stereo routing.
// Define TONE_MIXER_SAT_EN to clamp the mix instead of scaling it down.
module tone_mixer #(
    parameter int          NCH      = 2,
    parameter int          DIV_W    = 22,
    parameter int          VOL_W    = 4,
    parameter int          RAMP_DIV = 100000,
    parameter logic [15:0] AMP_STEP = 16'h0200
) (
    input logic         clk,
    input logic         rst,
    tone_mixer_if.slave bus
);
    localparam int LG = (NCH > 1) ? $clog2(NCH) : 0;
    localparam int SW = 17 + LG;
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(RAMP_DIV - 1);

    logic [PW-1:0]    pre;
    logic             tick;
    logic [DIV_W-1:0] cnt [NCH];
    logic             sq  [NCH];
    logic [VOL_W-1:0] env [NCH];

    logic [DIV_W-1:0]   nd  [NCH];
    logic [VOL_W-1:0]   vol [NCH];
    logic signed [15:0] smp [NCH];
    logic signed [SW-1:0] sum_l, sum_r;

    assign tick = (pre == PRE_MAX);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            nd[i]  = bus.note_div[i*DIV_W +: DIV_W];
            vol[i] = bus.volume[i*VOL_W +: VOL_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // Counter wraps on >= so a shortened divider never runs to full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                sq[i]  <= 1'b0;
                env[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (nd[i] == '0) begin
                    cnt[i] <= '0;
                    sq[i]  <= 1'b0;
                end else if (cnt[i] >= nd[i]) begin
                    cnt[i] <= '0;
                    sq[i]  <= ~sq[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                if (tick) begin
                    if (bus.gate[i] && env[i] < vol[i])
                        env[i] <= env[i] + 1'b1;
                    else if (bus.gate[i] && env[i] > vol[i])
                        env[i] <= env[i] - 1'b1;
                    else if (!bus.gate[i] && env[i] != '0)
                        env[i] <= env[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NCH; i++) begin
            logic signed [15:0] mag;
            mag = AMP_STEP * {{(16-VOL_W){1'b0}}, env[i]};
            if (nd[i] == '0)
                smp[i] = '0;
            else
                smp[i] = sq[i] ? mag : -mag;
            if (bus.route[2*i])
                sum_l = sum_l + {{(SW-16){smp[i][15]}}, smp[i]};
            if (bus.route[2*i+1])
                sum_r = sum_r + {{(SW-16){smp[i][15]}}, smp[i]};
        end
    end

    function automatic logic [15:0] fold(input logic signed [SW-1:0] s);
`ifdef TONE_MIXER_SAT_EN
        if (s > SW'(32767))
            return 16'h7FFF;
        else if (s < SW'(-32768))
            return 16'h8000;
        else
            return s[15:0];
`else
        return 16'(s >>> LG);
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.audio_left  <= '0;
            bus.audio_right <= '0;
            bus.active      <= '0;
        end else begin
            bus.audio_left  <= fold(sum_l);
            bus.audio_right <= fold(sum_r);
            for (int i = 0; i < NCH; i++)
                bus.active[i] <= (env[i] != '0);
        end
    end
endmodule

// File: tb/tb_tone_mixer.sv
// Scoreboard bench for tone_mixer: a cycle model predicts every output
// sample; directed checks cover reset, ramp, release, mix, mute and volume drop.
module tb_tone_mixer;
    localparam int          NCH   = 2;
    localparam int          DIV_W = 22;
    localparam int          VOL_W = 4;
    localparam int          RDIV  = 4;
    localparam logic [15:0] AMP   = 16'h0800;

`ifdef TONE_MIXER_SAT_EN
    localparam logic [15:0] ONE_HI = 16'h7800;
    localparam logic [15:0] ONE_LO = 16'h8800;
    localparam logic [15:0] MIX_HI = 16'h7FFF;
    localparam logic [15:0] MIX_LO = 16'h8000;
    localparam logic [15:0] V5_HI  = 16'h2800;
`else
    localparam logic [15:0] ONE_HI = 16'h3C00;
    localparam logic [15:0] ONE_LO = 16'hC400;
    localparam logic [15:0] MIX_HI = 16'h7800;
    localparam logic [15:0] MIX_LO = 16'h8800;
    localparam logic [15:0] V5_HI  = 16'h1400;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_mixer_if #(.NCH(NCH), .DIV_W(DIV_W), .VOL_W(VOL_W)) bus ();

    tone_mixer #(
        .NCH(NCH), .DIV_W(DIV_W), .VOL_W(VOL_W),
        .RAMP_DIV(RDIV), .AMP_STEP(AMP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0]    l;
        logic [15:0]    r;
        logic [NCH-1:0] a;
    } exp_t;

    exp_t sb[$];
    int   m_pre;
    int   m_cnt [NCH];
    int   m_sq  [NCH];
    int   m_env [NCH];

    function automatic logic [15:0] fold(input int s);
`ifdef TONE_MIXER_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
`else
        return 16'(s >>> 1);
`endif
    endfunction

    // Reference model: output at an edge reflects state before that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre <= 0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] <= 0;
                m_sq[i]  <= 0;
                m_env[i] <= 0;
            end
            sb.delete();
        end else begin
            automatic int   sl = 0;
            automatic int   sr = 0;
            automatic bit   tk = (m_pre == RDIV - 1);
            automatic exp_t e  = '0;
            for (int i = 0; i < NCH; i++) begin
                automatic int nd  = int'(bus.note_div[i*DIV_W +: DIV_W]);
                automatic int vl  = int'(bus.volume[i*VOL_W +: VOL_W]);
                automatic bit g   = bus.gate[i];
                automatic int smp = (nd == 0) ? 0 : m_env[i] * int'(AMP);
                if (m_sq[i] == 0) smp = -smp;
                if (bus.route[2*i])   sl += smp;
                if (bus.route[2*i+1]) sr += smp;
                e.a[i] = (m_env[i] != 0);
                if (nd == 0) begin
                    m_cnt[i] <= 0;
                    m_sq[i]  <= 0;
                end else if (m_cnt[i] >= nd) begin
                    m_cnt[i] <= 0;
                    m_sq[i]  <= 1 - m_sq[i];
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end
                if (tk) begin
                    if (g && m_env[i] < vl)       m_env[i] <= m_env[i] + 1;
                    else if (g && m_env[i] > vl)  m_env[i] <= m_env[i] - 1;
                    else if (!g && m_env[i] > 0)  m_env[i] <= m_env[i] - 1;
                end
            end
            e.l = fold(sl);
            e.r = fold(sr);
            sb.push_back(e);
            m_pre <= tk ? 0 : m_pre + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_left", bus.audio_left, e.l);
            check("sb_right", bus.audio_right, e.r);
            check("sb_active", 16'(bus.active), 16'(e.a));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic span(input int n, output logic [15:0] hi,
                        output logic [15:0] lo);
        logic signed [15:0] v, h, l;
        h = 16'sh8000;
        l = 16'sh7FFF;
        repeat (n) begin
            @(negedge clk);
            v = bus.audio_left;
            if (v > h) h = v;
            if (v < l) l = v;
        end
        hi = h;
        lo = l;
    endtask

    task automatic set_ch(input int ch, input int nd, input int vl);
        bus.note_div[ch*DIV_W +: DIV_W] = DIV_W'(nd);
        bus.volume[ch*VOL_W +: VOL_W]   = VOL_W'(vl);
    endtask

    logic [15:0] hi, lo;

    initial begin
        bus.note_div = '0;
        bus.volume   = '0;
        bus.gate     = '0;
        bus.route    = '0;
        step(2);
        check("rst_left", bus.audio_left, 16'h0000);
        check("rst_right", bus.audio_right, 16'h0000);
        check("rst_active", 16'(bus.active), 16'h0000);

        // Single channel ramp to full level, left only.
        rst = 1'b0;
        set_ch(0, 3, 15);
        bus.gate  = 2'b01;
        bus.route = 4'b0001;
        step(70);
        span(8, hi, lo);
        check("ramp_hi", hi, ONE_HI);
        check("ramp_lo", lo, ONE_LO);
        check("ramp_right", bus.audio_right, 16'h0000);
        step(1);

        bus.gate = 2'b00;
        step(20);
        check("rel_mid_active", 16'(bus.active), 16'h0001);
        step(46);
        check("rel_end_active", 16'(bus.active), 16'h0000);

        // Two in-phase channels summed on the left.
        rst = 1'b1;
        set_ch(0, 3, 15);
        set_ch(1, 3, 15);
        bus.gate  = 2'b11;
        bus.route = 4'b0101;
        step(1);
        rst = 1'b0;
        step(70);
        span(8, hi, lo);
        check("mix_hi", hi, MIX_HI);
        check("mix_lo", lo, MIX_LO);
        step(3);

        // Reset in the middle of a note.
        rst = 1'b1;
        #1;
        check("midrst_left", bus.audio_left, 16'h0000);
        check("midrst_active", 16'(bus.active), 16'h0000);
        step(1);
        rst = 1'b0;
        step(6);
        check("restart_active", 16'(bus.active), 16'h0003);
        step(10);

        // Muted channel still runs its envelope.
        rst = 1'b1;
        set_ch(0, 3, 15);
        set_ch(1, 0, 8);
        bus.gate  = 2'b10;
        bus.route = 4'b1111;
        step(1);
        rst = 1'b0;
        step(6);
        check("mute_active", 16'(bus.active), 16'h0002);
        span(8, hi, lo);
        check("mute_hi", hi, 16'h0000);
        check("mute_right", bus.audio_right, 16'h0000);
        step(1);

        // Volume drop from full to 5.
        bus.gate = 2'b11;
        step(70);
        set_ch(0, 3, 5);
        step(50);
        span(8, hi, lo);
        check("vdrop_hi", hi, V5_HI);
        check("vdrop_lo", lo, 16'(-int'(V5_HI)));
        step(1);

        // Shrink divider below the running count, then random traffic.
        set_ch(0, 1, 5);
        step(12);
        for (int k = 0; k < 150; k++) begin
            set_ch(0, int'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
            set_ch(1, int'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
            bus.gate  = 2'($urandom_range(0, 3));
            bus.route = 4'($urandom_range(0, 15));
            step(int'($urandom_range(1, 6)));
        end
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
